// File: rtl/median_window_ctrl.sv
// 3x3 median window sequencer: two line buffers feed a sliding window, then an en/done handshake with the median engine.
// Optional MEDIAN_CTRL_TIMEOUT_EN: bounds the WAIT on med_done_i and substitutes the centre pixel on expiry.
module median_window_ctrl #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  pix_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic [71:0] win_o,
  output logic        med_en_o,
  input  logic [7:0]  med_data_i,
  input  logic        med_done_i,
  output logic [7:0]  out_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        err_o
);

  // state   | meaning
  // IDLE    | waiting for start_i
  // FILL    | accepting pixels until a full 3x3 window is formed
  // START   | window stable, engine enabled
  // WAIT    | engine enabled, waiting for med_done_i
  // RELEASE | engine enable dropped for one cycle to reset it
  // OUT     | presenting the filtered pixel downstream
  typedef enum logic [2:0] {IDLE, FILL, START, WAIT, RELEASE, OUT} state_t;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  if (IMG_W < 3 || IMG_H < 3 || TIMEOUT < 1) begin : g_bad_param
    $error("median_window_ctrl: IMG_W/IMG_H must be >= 3 and TIMEOUT >= 1");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [71:0]     win_q, win_d;
  logic [7:0]      out_q, out_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            pix_acc;
  logic [7:0]      lb0_q [IMG_W];
  logic [7:0]      lb1_q [IMG_W];
`ifdef MEDIAN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    out_d   = out_q;
    last_d  = last_q;
    done_d  = 1'b0;
    pix_acc = 1'b0;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        state_d = FILL;
        col_d   = '0;
        row_d   = '0;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      FILL: if (pix_valid_i) begin
        pix_acc = 1'b1;
        // Each window row is three bytes; shift left one column, new column enters at the right.
        for (int r = 0; r < 3; r++) win_d[24*r +: 16] = win_q[24*r+8 +: 16];
        win_d[23:16] = lb1_q[col_q];
        win_d[47:40] = lb0_q[col_q];
        win_d[71:64] = pix_i;
        last_d = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
        if (col_q == CW'(IMG_W-1)) begin
          col_d = '0;
          row_d = last_d ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
        if (row_q >= RW'(2) && col_q >= CW'(2)) state_d = START;
      end
      START: begin
        state_d = WAIT;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        tmr_d   = TW'(TIMEOUT);
`endif
      end
      WAIT: begin
        if (med_done_i) begin
          out_d   = med_data_i;
          state_d = RELEASE;
        end
`ifdef MEDIAN_CTRL_TIMEOUT_EN
        else if (tmr_q == TW'(1)) begin
          out_d   = win_q[39:32];
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          tmr_d   = tmr_q - TW'(1);
        end
`endif
      end
      RELEASE: state_d = OUT;
      OUT: if (out_ready_i) begin
        if (last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      out_q   <= out_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  // Line buffers are not reset: every entry is rewritten before a window reads it.
  always_ff @(posedge clk_i) begin
    if (pix_acc) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_i;
    end
  end

  assign pix_ready_o  = (state_q == FILL);
  assign med_en_o     = (state_q == START) || (state_q == WAIT);
  assign out_valid_o  = (state_q == OUT);
  assign busy_o       = (state_q != IDLE);
  assign win_o        = win_q;
  assign out_o        = out_q;
  assign frame_done_o = done_q;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Scoreboard bench for median_window_ctrl: a reference model queues expected medians per frame,
// a monitor pops them on every output transfer; a behavioural engine answers the en/done handshake.
module tb_median_window_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int TO = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  pix_i = '0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [71:0] win_o;
  logic        med_en_o;
  logic [7:0]  med_data_i = '0;
  logic        med_done_i = 1'b0;
  logic [7:0]  out_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        busy_o;
  logic        frame_done_o;
  logic        err_o;

  median_window_ctrl #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .win_o(win_o), .med_en_o(med_en_o), .med_data_i(med_data_i), .med_done_i(med_done_i),
    .out_o(out_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  img [H][W];
  int          outs_seen;
  int          eng_mode;   // 0: latency 12, 1: latency 5..30, 2: never answers
  bit          eng_noise;
  int          eng_cnt = 0;
  int          eng_lat = 12;
  logic [71:0] eng_win;
  bit          prev_done = 1'b0;
  bit          fin, abort;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] median9(input logic [7:0] v[9]);
    logic [7:0] a[9];
    logic [7:0] t;
    a = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  function automatic logic [7:0] win_median(input logic [71:0] w);
    logic [7:0] v[9];
    for (int k = 0; k < 9; k++) v[k] = w[8*k +: 8];
    return median9(v);
  endfunction

  // Reference model: the median of every interior neighbourhood, in raster order of centre.
  task automatic build_frame(input bit rand_pix, input bit centre);
    logic [7:0] v[9];
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rand_pix ? 8'($urandom) : 8'(16*r + c);
    for (int r = 1; r < H-1; r++)
      for (int c = 1; c < W-1; c++) begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) v[3*dr+dc] = img[r-1+dr][c-1+dc];
        exp_q.push_back(centre ? img[r][c] : median9(v));
      end
  endtask

  task automatic chk_zero_outputs();
    chk("rst_pix_ready", pix_ready_o, 0);
    chk("rst_med_en", med_en_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_out", out_o, 0);
    chk("rst_win", win_o, 0);
  endtask

  // Engine model: answers after a latency counted from med_en_o rising, resets when med_en_o drops.
  initial forever begin
    @(posedge clk_i); #1;
    if (prev_done) begin
      chk("en_low_in_release", med_en_o, 0);
      chk("no_valid_in_release", out_valid_o, 0);
    end
    prev_done = 1'b0;
    if (rst_i || !med_en_o) begin
      eng_cnt    = 0;
      med_done_i = eng_noise ? 1'($urandom) : 1'b0;
      med_data_i = 8'($urandom);
    end else begin
      eng_cnt++;
      if (eng_cnt == 1) begin
        eng_win = win_o;
        eng_lat = (eng_mode == 1) ? int'($urandom_range(30, 5)) : 12;
      end else begin
        chk("win_stable", win_o, eng_win);
      end
      if (eng_mode != 2 && eng_cnt == eng_lat) begin
        med_done_i = 1'b1;
        med_data_i = win_median(win_o);
        prev_done  = 1'b1;
      end else begin
        med_done_i = 1'b0;
        med_data_i = 8'($urandom);
      end
    end
  end

  // Monitor: every transfer on the output port pops one expected value.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_output: got %0d expected none at %0t", out_o, $time);
      end else begin
        chk("out_pix", out_o, exp_q.pop_front());
      end
      outs_seen++;
    end
  end

  // rmode: 0 ready always, 1 ready random, 2 stall 10 cycles at the first output
  task automatic run_frame(input bit rand_pix, input int emode, input bit noise, input bit gaps,
                           input int rmode, input bit rst_mid, input bit centre);
    build_frame(rand_pix, centre);
    eng_mode  = emode;
    eng_noise = noise;
    outs_seen = 0;
    fin       = 1'b0;
    abort     = 1'b0;
    @(posedge clk_i); #1;
    start_i     = 1'b1;
    out_ready_i = (rmode != 2);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("err_clear_after_start", err_o, 0);
    fork
      begin
        int idx;
        int g;
        bit acc;
        idx = 0;
        g   = 0;
        while (idx < W*H && !abort && g < 5000) begin
          g++;
          pix_valid_i = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
          pix_i       = img[idx / W][idx % W];
          start_i     = gaps ? ($urandom_range(5, 0) == 0) : 1'b0;
          @(negedge clk_i);
          acc = pix_valid_i && pix_ready_o;
          @(posedge clk_i); #1;
          if (acc) idx++;
        end
        pix_valid_i = 1'b0;
        start_i     = 1'b0;
      end
      begin
        bit stalled;
        stalled = 1'b0;
        while (!fin && !abort) begin
          @(posedge clk_i); #1;
          if (rmode == 2 && !stalled) begin
            out_ready_i = 1'b0;
            if (out_valid_o) begin
              stalled = 1'b1;
              for (int i = 0; i < 10; i++) begin
                @(negedge clk_i);
                chk("stall_valid", out_valid_o, 1);
                chk("stall_data", out_o, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
                chk("stall_pix_ready", pix_ready_o, 0);
                @(posedge clk_i); #1;
              end
              out_ready_i = 1'b1;
            end
          end else begin
            out_ready_i = (rmode == 1) ? 1'($urandom) : 1'b1;
          end
        end
      end
      begin
        int g;
        g = 0;
        while (!fin && g < 6000) begin
          @(negedge clk_i);
          g++;
          if (rst_mid && outs_seen == 1 && med_en_o && eng_cnt >= 2) begin
            #2 rst_i = 1'b1;
            #1 chk_zero_outputs();
            abort = 1'b1;
            exp_q.delete();
            fin = 1'b1;
          end else if (frame_done_o) begin
            chk("busy_at_done", busy_o, 0);
            chk("outputs_drained", exp_q.size(), 0);
            chk("err_at_done", err_o, centre);
            @(negedge clk_i);
            chk("frame_done_single", frame_done_o, 0);
            fin = 1'b1;
          end
        end
        if (!fin) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL frame_timeout: got no frame_done_o expected one within %0d cycles", g);
          abort = 1'b1;
          fin   = 1'b1;
        end
      end
    join
    if (rst_mid) begin
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
    end
    exp_q.delete();
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    eng_mode  = 0;
    eng_noise = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_zero_outputs();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    run_frame(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // pixel 16r+c, latency 12
    run_frame(1'b0, 1, 1'b0, 1'b0, 1, 1'b0, 1'b0);   // random latency, random ready
    run_frame(1'b0, 0, 1'b0, 1'b0, 2, 1'b0, 1'b0);   // stalled first output
    run_frame(1'b0, 1, 1'b0, 1'b0, 0, 1'b1, 1'b0);   // reset in WAIT of second window
    run_frame(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // full frame after reset
    run_frame(1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);   // gaps, stray start_i and stray med_done_i
    for (int f = 0; f < 3; f++)
      run_frame(1'b1, 1, 1'b1, 1'b1, 1, 1'b0, 1'b0); // random pixels
`ifdef MEDIAN_CTRL_TIMEOUT_EN
    run_frame(1'b0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b1);   // engine silent: centre pixels, err_o
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/median_window_ctrl.md
Name: median_window_ctrl

Overview:
Sequencer that streams a raster image, builds 3x3 windows with two line buffers, and drives the existing 3x3 median engine through its en/done handshake. It sits between the pixel source and the median engine, and emits one filtered pixel per interior position over a valid/ready output.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in lines (>=3)
TIMEOUT, 64, max cycles waiting for engine done (used only with MEDIAN_CTRL_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start a frame; ignored while busy_o=1
pix_i  in  8  input pixel, raster order
pix_valid_i  in  1  pix_i valid
pix_ready_o  out  1  controller accepts pix_i
win_o  out  72  window to engine; byte k = win_o[8k+7:8k]; k=0 top-left, raster order, k=4 centre
med_en_o  out  1  engine enable
med_data_i  in  8  engine result
med_done_i  in  1  engine result valid
out_o  out  8  filtered pixel
out_valid_o  out  1  out_o valid
out_ready_i  in  1  downstream accepts out_o
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse after last output accepted
err_o  out  1  engine timeout flag, sticky per frame

Behaviour:
- Reset: all outputs 0, state IDLE, row/col counters 0. Line buffer contents not cleared (refilled before use).
- States: IDLE, FILL, START, WAIT, RELEASE, OUT.
- IDLE: start_i=1 -> FILL, busy_o=1, err_o cleared.
- FILL: pix_ready_o=1. Handshake on pix_valid_i & pix_ready_o: shift the window left, load new column (line buf 1, line buf 0, pix_i), update line buffers, advance col (wraps at IMG_W-1 to 0, row+1). If the accepted pixel has row>=2 and col>=2 -> START, else stay in FILL.
- START: latch win_o and assert med_en_o=1 -> WAIT. win_o is stable from START until RELEASE.
- WAIT: med_en_o held at 1. When med_done_i=1, capture med_data_i into out_o -> RELEASE.
- RELEASE: med_en_o=0 for exactly 1 cycle, which resets the engine. out_valid_o=1 -> OUT.
- OUT: hold out_o/out_valid_o until out_ready_i=1. On acceptance: last pixel (row IMG_H-1, col IMG_W-1) -> frame_done_o pulse, busy_o=0, IDLE; else FILL.
- pix_ready_o=0 in every state except FILL; at most one window in flight.
- Outputs per frame: exactly (IMG_W-2)*(IMG_H-2), in raster order of centre position. Border pixels produce no output.
- Gaps in pix_valid_i only stall FILL.
- med_done_i outside WAIT is ignored.
- start_i while busy_o=1 is ignored.
- Reset mid-operation: immediate return to reset values, including med_en_o=0. Any partial frame is discarded.

Optional Feature:
MEDIAN_CTRL_TIMEOUT_EN: a cycle counter runs in WAIT. If it reaches TIMEOUT without med_done_i, out_o takes the centre pixel (win_o byte 4), err_o is set to 1, and the state goes to RELEASE; the frame continues normally. Without the macro, WAIT waits indefinitely and err_o is tied to 0.

Test Plan:
- IMG_W=4, IMG_H=4, pixel(r,c)=16r+c, engine model done 12 cycles after en -> outputs 17,18,33,34 in order, then one frame_done_o pulse, busy_o=0.
- Same frame, engine latency randomized 5..30 -> med_en_o high continuously START..done, low exactly 1 cycle in RELEASE, win_o unchanged while med_en_o=1.
- out_ready_i held 0 for 10 cycles at the first output -> out_valid_o=1 and out_o=17 stable throughout, pix_ready_o=0; resumes correctly.
- rst_i pulsed during WAIT of the second window -> all outputs 0 asynchronously; a new start_i then gives the full correct 4-output frame.
- Macro defined, TIMEOUT=64, med_done_i never asserted -> after 64 WAIT cycles out_o=17 (centre), err_o=1; all 4 outputs emitted as centre pixels.
- start_i pulsed mid-frame plus random pix_valid_i gaps -> start_i ignored, output sequence identical to the first scenario.
